// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - runtime-programmable integer clock divider with glitch-free ratio switching
//
// Purpose:
//   Divides sys_clk by a runtime-programmable integer ratio N in [2, 2^CNT_W-1].
//   clk_out is high for ceil(N/2) cycles and low for floor(N/2) cycles of each
//   period. tick is a one-cycle clock enable at each period start.
//   A new ratio may be loaded at any time. It only takes effect at a period
//   boundary, so clk_out never carries a runt pulse.
//
// Ports:
//   sys_clk    in   system clock, all logic on the rising edge
//   sys_rst    in   asynchronous active-high reset
//   en         in   count enable; 0 freezes the divider phase and outputs
//   div_val    in   requested ratio N (values below 2 are clamped to 2)
//   div_load   in   one-cycle strobe; captures div_val as the pending ratio
//   clk_out    out  divided clock (registered)
//   tick       out  one-cycle pulse with each clk_out rising edge (registered)
//   div_active out  ratio currently in effect
//   load_ack   out  one-cycle pulse in the cycle a pending ratio takes effect

module clk_div_prog #(
    parameter int CNT_W       = 8,
    parameter int DIV_DEFAULT = 6
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] div_active,
    output logic             load_ack
);

    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO  = CNT_W'(2);
    localparam logic [CNT_W-1:0] ZERO = '0;

    // Reset ratio; ratios below 2 cannot produce both a high and a low phase.
    localparam logic [CNT_W-1:0] DIV_RST = (DIV_DEFAULT < 2) ? CNT_W'(2) : CNT_W'(DIV_DEFAULT);

    // Phase counter 0..N-1 and pending-ratio holding register.
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] pend_val;
    logic             pend_vld;

    // Next-state helpers.
    logic             wrap;
    logic             apply;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] div_eff;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] load_val;

    always_comb begin
        wrap     = (cnt == (div_active - ONE));
        cnt_next = wrap ? ZERO : (cnt + ONE);

        // The pending ratio is applied only on an enabled wrap, and only if it
        // was already pending before this edge; a load on this same edge waits.
        apply    = en && wrap && pend_vld;

        // The high-phase length of the period that starts at this edge comes
        // from the ratio that will be in effect for that period.
        div_eff  = apply ? pend_val : div_active;
        high_len = div_eff - (div_eff >> 1);

        load_val = (div_val < TWO) ? TWO : div_val;
    end

    // Divider phase and registered outputs.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt        <= DIV_RST - ONE;
            div_active <= DIV_RST;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
            load_ack   <= 1'b0;
        end else if (en) begin
            cnt      <= cnt_next;
            clk_out  <= (cnt_next < high_len);
            tick     <= (cnt_next == ZERO);
            load_ack <= apply;
            if (apply) begin
                div_active <= pend_val;
            end
        end else begin
            // Frozen: phase, level and ratio hold; strobes are suppressed.
            tick     <= 1'b0;
            load_ack <= 1'b0;
        end
    end

    // Pending ratio capture works regardless of en. A load coinciding with an
    // application replaces the value just consumed and stays pending.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pend_val <= DIV_RST;
            pend_vld <= 1'b0;
        end else if (div_load) begin
            pend_val <= load_val;
            pend_vld <= 1'b1;
        end else if (apply) begin
            pend_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - self-checking bench for clk_div_prog against a period-position reference model
module tb_clk_div_prog;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] div_val = 8'd0;
    logic       div_load = 1'b0;
    logic       clk_out;
    logic       tick;
    logic [7:0] div_active;
    logic       load_ack;

    clk_div_prog #(.CNT_W(8), .DIV_DEFAULT(6)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .en         (en),
        .div_val    (div_val),
        .div_load   (div_load),
        .clk_out    (clk_out),
        .tick       (tick),
        .div_active (div_active),
        .load_ack   (load_ack)
    );

    always #5 sys_clk = ~sys_clk;

    int vecs = 0;
    int errs = 0;
    int ack_seen = 0;

    // Reference model: position within the current period and period length.
    int m_n, m_pos, m_pend;
    bit m_pvld, m_clk, m_tick, m_ack;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_n    = 6;
        m_pos  = 5;
        m_pend = 0;
        m_pvld = 0;
        m_clk  = 0;
        m_tick = 0;
        m_ack  = 0;
    endtask

    task automatic check_outputs();
        chk("clk_out", {31'd0, clk_out}, {31'd0, m_clk});
        chk("tick", {31'd0, tick}, {31'd0, m_tick});
        chk("load_ack", {31'd0, load_ack}, {31'd0, m_ack});
        chk("div_active", {24'd0, div_active}, 32'(m_n));
    endtask

    // One clock edge with the given inputs, then model update and checks.
    task automatic step(input bit e, input bit ld, input int v);
        bit pv_before;
        int pend_before;
        en       = e;
        div_load = ld;
        div_val  = v[7:0];
        @(posedge sys_clk);
        pv_before   = m_pvld;
        pend_before = m_pend;
        if (e) begin
            m_pos = (m_pos + 1) % m_n;
            m_ack = (m_pos == 0) && pv_before;
            if (m_ack) begin
                m_n    = pend_before;
                m_pvld = 0;
            end
            m_clk  = (m_pos < (m_n + 1) / 2);
            m_tick = (m_pos == 0);
        end else begin
            m_tick = 0;
            m_ack  = 0;
        end
        if (ld) begin
            m_pend = (v < 2) ? 2 : v;
            m_pvld = 1;
        end
        #1;
        if (load_ack === 1'b1) ack_seen++;
        check_outputs();
        div_load = 1'b0;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step(1, 0, 0);
    endtask

    // Advance until the model sits at the given position (bounded).
    task automatic align(input int pos);
        int guard = 0;
        while (m_pos != pos && guard < 400) begin
            step(1, 0, 0);
            guard++;
        end
        chk("align_reached", 32'(m_pos), 32'(pos));
    endtask

    initial begin
        model_reset();
        #12;
        check_outputs();
        sys_rst = 1'b0;
        #20;
        check_outputs();

        // Default ratio 6: 1,1,1,0,0,0 from the first enabled edge.
        run(20);

        // Odd ratio 5.
        step(1, 1, 5);
        run(20);

        // Mid-period loads, last one wins, single ack.
        align(0);
        ack_seen = 0;
        step(1, 1, 9);
        run(2);
        step(1, 1, 4);
        run(12);
        chk("last_wins_acks", 32'(ack_seen), 32'd1);
        chk("last_wins_ratio", {24'd0, div_active}, 32'd4);

        // Load on the wrap edge itself: applied one full period later.
        align(3);
        step(1, 1, 7);
        chk("wrap_load_not_yet", {24'd0, div_active}, 32'd4);
        run(20);

        // Clamp to 2, then maximum ratio 255.
        step(1, 1, 0);
        run(12);
        step(1, 1, 255);
        run(520);

        // Enable gating mid-high-phase with ratio 6.
        step(1, 1, 6);
        run(260);
        align(1);
        for (int i = 0; i < 7; i++) step(0, 0, 0);
        chk("gated_level", {31'd0, clk_out}, 32'd1);
        run(14);

        // Reset during a low phase with a load pending.
        align(3);
        step(1, 1, 3);
        chk("pending_before_rst", 32'(m_pvld), 32'd1);
        #2;
        sys_rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge sys_clk);
        #3;
        check_outputs();
        sys_rst = 1'b0;
        ack_seen = 0;
        run(30);
        chk("rst_discard_acks", 32'(ack_seen), 32'd0);
        chk("rst_discard_ratio", {24'd0, div_active}, 32'd6);

        // Randomized enables, loads and ratios.
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 15);
            if (r == 0) step(1, 1, $urandom_range(0, 255));
            else if (r < 4) step(1, 1, $urandom_range(0, 12));
            else if (r < 6) step(0, ($urandom_range(0, 3) == 0), $urandom_range(0, 12));
            else step(1, 0, $urandom_range(0, 255));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Runtime-programmable integer clock divider: the parametrised successor to the fixed divide-by-six block. It generates a divided clock `clk_out` for any ratio N in [2, 2^CNT_W−1], with duty high = ceil(N/2) and low = floor(N/2) cycles. It also produces a one-cycle `tick` clock-enable at each period start. New ratios are accepted at any time but applied only at a period boundary, so the output never carries a runt pulse. It sits between the system clock and slow peripherals such as LED blinkers, UART baud timing and key scanning.

## Interface
- `CNT_W`, 8: counter and ratio width in bits.
- `DIV_DEFAULT`, 6: ratio after reset; values below 2 are clamped to 2.
- `sys_clk` input 1: system clock; all logic on its rising edge.
- `sys_rst` input 1: reset, asynchronous and active-high.
- `en` input 1: count enable; 0 freezes divider state.
- `div_val` input CNT_W: requested ratio N.
- `div_load` input 1: one-cycle strobe; captures `div_val` as the pending ratio.
- `clk_out` output 1: divided clock (registered).
- `tick` output 1: one-cycle pulse coinciding with each `clk_out` rising edge (registered).
- `div_active` output CNT_W: ratio currently in effect.
- `load_ack` output 1: one-cycle pulse in the cycle the pending ratio takes effect.

## Operation
- State:
  - `cnt` (CNT_W), the phase 0..N−1.
  - `div_active`.
  - `pend_val` / `pend_vld`.
- H = N − (N>>1), i.e. ceil(N/2).
- Reset values:
  - `cnt` = Nd−1, where Nd = clamped DIV_DEFAULT.
  - `div_active` = Nd.
  - `clk_out` = 0, `tick` = 0, `load_ack` = 0.
  - `pend_vld` = 0.
- Per rising edge with `en`=1:
  - `wrap` = (`cnt` == `div_active`−1).
  - `cnt_next` = `wrap` ? 0 : `cnt`+1.
  - `cnt` <= `cnt_next`.
  - `clk_out` <= (`cnt_next` < H).
  - `tick` <= (`cnt_next` == 0).
- Ratio update:
  - `div_load`=1 sets `pend_val` <= max(`div_val`, 2) and `pend_vld` <= 1. This happens regardless of `en`.
  - On an enabled `wrap` edge with `pend_vld` already 1 before that edge: `div_active` <= `pend_val`, `pend_vld` <= 0, `load_ack` <= 1.
  - H for the new period is taken from the new ratio. `clk_out` rises at this edge either way, since 0 < H always.
  - `load_ack` is 0 on all other edges.
- Simultaneous events:
  - `div_load` on the same edge as a wrap is stored as pending and applies at the next wrap, not this one.
  - If `div_load` arrives on the same edge as a pending application, the current `pend_val` is applied, the new value becomes pending, and `pend_vld` stays 1.
  - Multiple loads before a wrap: the last one wins. Only one `load_ack` is issued.
- `en`=0:
  - `cnt`, `clk_out`, `div_active` and `pend_*` hold; `div_load` capture still works.
  - `tick` <= 0 and `load_ack` <= 0.
  - On re-enable, counting resumes from the held phase with no extra edge.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). The pending ratio is discarded.
- `cnt` never exceeds `div_active`−1, since it only increments up to `div_active`−1 and then wraps.

## Timing
- First enabled edge after reset release: `clk_out` 0→1 and `tick`=1.
- With `en` held at 1, each period is exactly N edges:
  - `clk_out` is high for H edges and low for N−H.
  - `tick` pulses are N cycles apart.
- N=2 gives the fastest output: a toggle on every edge.
- Ratio-change latency: at most N_old + 1 enabled edges from the `div_load` edge to `load_ack`.
- Outputs depend on registered state only; there are no combinational paths from inputs.

## Test plan
- **Reset default (CNT_W=8, DIV_DEFAULT=6), `en`=1:** `clk_out` runs 1,1,1,0,0,0 repeating from the first edge; `tick` pulses every 6 cycles; `div_active`=6.
- **Odd ratio:** load 5 → after `load_ack`, `clk_out` runs 1,1,1,0,0 repeating, `tick` every 5 cycles; no high or low run shorter than 2 across the switch.
- **Mid-period load and last-wins:**
  - Load 9, then 4 two cycles later → exactly one `load_ack`, at the next wrap; `div_active`=4; then 1,1,0,0.
  - Load asserted on the wrap edge itself → applied one full period later.
- **Clamp and max:**
  - Load 0 → `div_active`=2, `clk_out` toggles every edge.
  - Load 255 → 128 high, 127 low, `tick` every 255 cycles.
- **Enable gating:** drop `en` for 7 cycles mid-high-phase → `clk_out` holds 1, `tick`=0 throughout; the remaining high count resumes unchanged.
- **Reset mid-operation:** assert `sys_rst` during a low phase with a load pending → outputs 0 and `div_active`=6 immediately; after release the pending ratio is never applied.
